// File: rtl/moravec_pkg.sv
// Shared types and constants for the Moravec corner scan engine: FSM states,
// 3x3 window slot indices and the response width helper.
package moravec_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_PIX = 3'd1,
        FETCH     = 3'd2,
        CALC      = 3'd3,
        WRITE     = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Window slots in row-major order; the centre pixel sits at slot 4.
    localparam int NB_NW    = 0;
    localparam int NB_N     = 1;
    localparam int NB_NE    = 2;
    localparam int NB_W     = 3;
    localparam int NB_C     = 4;
    localparam int NB_E     = 5;
    localparam int NB_SW    = 6;
    localparam int NB_S     = 7;
    localparam int NB_SE    = 8;
    localparam int WIN_SIZE = 9;

    function automatic int resp_width(input int pw);
        return 2 * pw + 1;
    endfunction

endpackage

// File: rtl/moravec_if.sv
// Bundle between the scan engine, the source pixel RAM and the corner-map RAM.
interface moravec_if import moravec_pkg::*; #(
    parameter int AW = 7,
    parameter int PW = 8
) ();

    // start is a request taken only in IDLE (busy high means not ready, no
    // queueing); rd_data must follow rd_addr combinationally in the same
    // cycle; each write holds wr_en/wr_addr/wr_data/harris_bit for 2 cycles.
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic          harris_bit;
    state_t        dbg_state;

    modport master (
        input  start,
        input  rd_data,
        output busy,
        output done,
        output rd_addr,
        output wr_en,
        output wr_addr,
        output wr_data,
        output harris_bit,
        output dbg_state
    );

    modport slave (
        output start,
        output rd_data,
        input  busy,
        input  done,
        input  rd_addr,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  harris_bit,
        input  dbg_state
    );

endinterface

// File: rtl/moravec_response.sv
// Combinational 3x3 Moravec response: minimum over four directions of the
// summed squared differences between opposite neighbours and the centre.
module moravec_response import moravec_pkg::*; #(
    parameter int PW = 8
) (
    input  logic [WIN_SIZE-1:0][PW-1:0] win,
    output logic [2*PW:0]               resp
);

    localparam int RW = resp_width(PW);

    function automatic logic [RW-1:0] sq_diff(input logic [PW-1:0] a, input logic [PW-1:0] ctr);
        logic signed [PW:0]     d;
        logic signed [2*PW+1:0] dx;
        logic signed [2*PW+1:0] p;
        d  = $signed({1'b0, a}) - $signed({1'b0, ctr});
        dx = {{(PW + 1){d[PW]}}, d};
        p  = dx * dx;
        // A square of a (P+1)-bit difference always fits in 2P unsigned bits.
        return {1'b0, p[2*PW-1:0]};
    endfunction

    logic [RW-1:0] e_h;
    logic [RW-1:0] e_v;
    logic [RW-1:0] e_d;
    logic [RW-1:0] e_a;
    logic [RW-1:0] min_hv;
    logic [RW-1:0] min_da;

    assign e_h = sq_diff(win[NB_W],  win[NB_C]) + sq_diff(win[NB_E],  win[NB_C]);
    assign e_v = sq_diff(win[NB_N],  win[NB_C]) + sq_diff(win[NB_S],  win[NB_C]);
    assign e_d = sq_diff(win[NB_NW], win[NB_C]) + sq_diff(win[NB_SE], win[NB_C]);
    assign e_a = sq_diff(win[NB_NE], win[NB_C]) + sq_diff(win[NB_SW], win[NB_C]);

    assign min_hv = (e_h < e_v) ? e_h : e_v;
    assign min_da = (e_d < e_a) ? e_d : e_a;
    assign resp   = (min_hv < min_da) ? min_hv : min_da;

endmodule

// File: rtl/moravec_detector.sv
// Raster scan engine: fetches each interior pixel's 3x3 window, scores it and
// writes pixel + corner bit to the corner-map RAM; border pixels write zero.
module moravec_detector import moravec_pkg::*; #(
    parameter int                    N          = 8,
    parameter int                    bitSize    = 6,
    parameter int                    pixelWidth = 8,
    parameter logic [2*pixelWidth:0] THRESH     = 17'd1000
) (
    input logic       clk,
    input logic       rst_n,
    moravec_if.master bus
);

    localparam int            AW       = bitSize + 1;
    localparam int            PW       = pixelWidth;
    localparam int            RW       = resp_width(PW);
    localparam logic [AW-1:0] SIDE     = AW'(N);
    localparam logic [AW-1:0] SIDE_M1  = AW'(N - 1);
    localparam logic [AW-1:0] LAST_PIX = AW'(N * N - 1);

    state_t                      state;
    logic [AW-1:0]               pix;
    logic [3:0]                  k;
    logic                        wr_phase;
    logic [WIN_SIZE-1:0][PW-1:0] win;
    logic [RW-1:0]               resp;

    logic          busy;
    logic          done;
    logic          wr_en;
    logic          harris_bit;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;

    logic [AW-1:0] ent_pix;
    logic          ent_border;
    logic [AW-1:0] ent_rd0;

    function automatic logic is_border(input logic [AW-1:0] p);
        logic [AW-1:0] r;
        logic [AW-1:0] c;
        r = p / SIDE;
        c = p % SIDE;
        return (r == '0) || (r == SIDE_M1) || (c == '0) || (c == SIDE_M1);
    endfunction

    // Address of window slot kk around pixel p: p + (kk/3 - 1)*N + (kk%3 - 1).
    function automatic logic [AW-1:0] nb_addr(input logic [AW-1:0] p, input logic [3:0] kk);
        logic [3:0] kr;
        logic [3:0] kc;
        kr = kk / 4'd3;
        kc = kk % 4'd3;
        return p - SIDE - AW'(1) + AW'(kr) * SIDE + AW'(kc);
    endfunction

    // START_PIX costs no cycle between pixels: the next pixel is decoded here
    // and the end of WRITE jumps straight to FETCH or WRITE.
    assign ent_pix    = (state == WRITE) ? pix + AW'(1) : pix;
    assign ent_border = is_border(ent_pix);
    assign ent_rd0    = nb_addr(ent_pix, 4'd0);

    moravec_response #(.PW(PW)) u_resp (
        .win  (win),
        .resp (resp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pix        <= '0;
            k          <= '0;
            wr_phase   <= 1'b0;
            win        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_addr    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            harris_bit <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= START_PIX;
                        busy  <= 1'b1;
                        pix   <= '0;
                    end
                end
                START_PIX: begin
                    if (ent_border) begin
                        state      <= WRITE;
                        wr_en      <= 1'b1;
                        wr_addr    <= ent_pix;
                        wr_data    <= '0;
                        harris_bit <= 1'b0;
                        wr_phase   <= 1'b0;
                    end else begin
                        state   <= FETCH;
                        k       <= '0;
                        rd_addr <= ent_rd0;
                    end
                end
                FETCH: begin
                    win[k] <= bus.rd_data;
                    if (k == 4'd8) begin
                        state   <= CALC;
                        rd_addr <= '0;
                    end else begin
                        k       <= k + 4'd1;
                        rd_addr <= nb_addr(pix, k + 4'd1);
                    end
                end
                CALC: begin
                    state      <= WRITE;
                    wr_en      <= 1'b1;
                    wr_addr    <= pix;
                    wr_data    <= win[NB_C];
                    harris_bit <= (resp > THRESH);
                    wr_phase   <= 1'b0;
                end
                WRITE: begin
                    if (!wr_phase) begin
                        wr_phase <= 1'b1;
                    end else begin
                        wr_phase   <= 1'b0;
                        wr_en      <= 1'b0;
                        wr_addr    <= '0;
                        wr_data    <= '0;
                        harris_bit <= 1'b0;
                        if (pix == LAST_PIX) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pix   <= '0;
                        end else begin
                            pix <= ent_pix;
                            if (ent_border) begin
                                state      <= WRITE;
                                wr_en      <= 1'b1;
                                wr_addr    <= ent_pix;
                                wr_data    <= '0;
                                harris_bit <= 1'b0;
                            end else begin
                                state   <= FETCH;
                                k       <= '0;
                                rd_addr <= ent_rd0;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.rd_addr    = rd_addr;
    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = wr_addr;
    assign bus.wr_data    = wr_data;
    assign bus.harris_bit = harris_bit;
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_moravec_detector.sv
// Bench: four detectors with thresholds 0/199/200/1000 scan one shared image in
// lockstep; a per-pixel model and a write scoreboard check every write.
module tb_moravec_detector;
    import moravec_pkg::*;

    localparam int NS   = 8;
    localparam int AW   = 7;
    localparam int PW   = 8;
    localparam int NPIX = 64;
    localparam int NDUT = 4;
    localparam int W    = 32;
    localparam int MAIN = 3;

    function automatic int thr_of(input int g);
        case (g)
            0:       return 0;
            1:       return 199;
            2:       return 200;
            default: return 1000;
        endcase
    endfunction

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic [PW-1:0]   img [NPIX];
    logic [NDUT-1:0] busy_v;
    logic [NDUT-1:0] done_v;
    logic [NDUT-1:0] wr_en_v;
    logic [NDUT-1:0] hb_v;
    logic [AW-1:0]   wr_addr_v [NDUT];
    logic [AW-1:0]   rd_addr_v [NDUT];
    logic [PW-1:0]   wr_data_v [NDUT];
    state_t          state_v   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        moravec_if #(.AW(AW), .PW(PW)) bus ();
        assign bus.start   = start;
        assign bus.rd_data = img[bus.rd_addr[5:0]];

        moravec_detector #(
            .N          (NS),
            .bitSize    (AW - 1),
            .pixelWidth (PW),
            .THRESH     (17'(thr_of(g)))
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign busy_v[g]    = bus.busy;
        assign done_v[g]    = bus.done;
        assign wr_en_v[g]   = bus.wr_en;
        assign hb_v[g]      = bus.harris_bit;
        assign wr_addr_v[g] = bus.wr_addr;
        assign rd_addr_v[g] = bus.rd_addr;
        assign wr_data_v[g] = bus.wr_data;
        assign state_v[g]   = bus.dbg_state;
    end

    // ---------------- model / scoreboard ----------------
    logic [W-1:0] exp_q [$];
    int           checks   = 0;
    int           failures = 0;
    int           idx     [NDUT];
    int           run_len [NDUT];
    bit           prev_busy [NDUT];
    logic [PW-1:0] ram [NDUT][NPIX];

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic int px(input int r, input int c);
        return int'(img[r * NS + c]);
    endfunction

    function automatic int sqd(input int a, input int b);
        return (a - b) * (a - b);
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int model_resp(input int r, input int c);
        int ctr;
        int eh;
        int ev;
        int ed;
        int ea;
        if (r == 0 || r == NS - 1 || c == 0 || c == NS - 1) return 0;
        ctr = px(r, c);
        eh  = sqd(px(r, c - 1), ctr)     + sqd(px(r, c + 1), ctr);
        ev  = sqd(px(r - 1, c), ctr)     + sqd(px(r + 1, c), ctr);
        ed  = sqd(px(r - 1, c - 1), ctr) + sqd(px(r + 1, c + 1), ctr);
        ea  = sqd(px(r - 1, c + 1), ctr) + sqd(px(r + 1, c - 1), ctr);
        return min2(min2(eh, ev), min2(ed, ea));
    endfunction

    function automatic int nz(input int g);
        int n = 0;
        for (int a = 0; a < NPIX; a++) if (ram[g][a] != '0) n++;
        return n;
    endfunction

    task automatic build_expected();
        exp_q.delete();
        for (int p = 0; p < NPIX; p++) begin
            int r = p / NS;
            int c = p % NS;
            bit brd = (r == 0 || r == NS - 1 || c == 0 || c == NS - 1);
            exp_q.push_back({AW'(p), brd ? 8'd0 : img[p], 17'(model_resp(r, c))});
        end
    endtask

    // One compare process: every write cycle of every detector against the model.
    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (!rst_n) begin
                idx[g]     = 0;
                run_len[g] = 0;
            end else begin
                if (busy_v[g] && !prev_busy[g]) begin
                    idx[g]     = 0;
                    run_len[g] = 0;
                    for (int a = 0; a < NPIX; a++) ram[g][a] = '0;
                end
                if (wr_en_v[g]) begin
                    if (run_len[g] == 2) begin
                        idx[g]++;
                        run_len[g] = 0;
                    end
                    check($sformatf("wr_in_range[%0d]", g), int'(idx[g] < exp_q.size()), 1);
                    if (idx[g] < exp_q.size()) begin
                        logic [W-1:0] e;
                        e = exp_q[idx[g]];
                        check($sformatf("wr_addr[%0d]", g), wr_addr_v[g], int'(e[31:25]));
                        check($sformatf("wr_data[%0d]", g), wr_data_v[g], int'(e[24:17]));
                        check($sformatf("harris_bit[%0d]@%0d", g, e[31:25]), hb_v[g],
                              (int'(e[16:0]) > thr_of(g)) ? 1 : 0);
                        check($sformatf("rd_addr_in_write[%0d]", g), rd_addr_v[g], 0);
                        ram[g][wr_addr_v[g][5:0]] = hb_v[g] ? wr_data_v[g] : 8'd0;
                    end
                    run_len[g]++;
                end else if (run_len[g] != 0) begin
                    check($sformatf("wr_len[%0d]", g), run_len[g], 2);
                    idx[g]++;
                    run_len[g] = 0;
                end
            end
            prev_busy[g] = busy_v[g];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle_outputs(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s_busy[%0d]", tag, g), busy_v[g], 0);
            check($sformatf("%s_done[%0d]", tag, g), done_v[g], 0);
            check($sformatf("%s_wr_en[%0d]", tag, g), wr_en_v[g], 0);
            check($sformatf("%s_hb[%0d]", tag, g), hb_v[g], 0);
            check($sformatf("%s_wr_addr[%0d]", tag, g), wr_addr_v[g], 0);
            check($sformatf("%s_wr_data[%0d]", tag, g), wr_data_v[g], 0);
            check($sformatf("%s_rd_addr[%0d]", tag, g), rd_addr_v[g], 0);
            check($sformatf("%s_state[%0d]", tag, g), int'(state_v[g]), int'(IDLE));
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_scan(input string tag, input bit mid_pulse);
        int n;
        bit seen;
        build_expected();
        pulse_start();
        check({tag, "_busy_rise"}, busy_v[MAIN], 1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 600) begin
            @(posedge clk);
            #1;
            n++;
            start = mid_pulse && (n == 50);
            if (done_v[MAIN]) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_edge"}, seen ? n : -1, 489);
        check({tag, "_done_all"}, int'(done_v), 15);
        check({tag, "_busy_fall"}, int'(busy_v), 0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse_len"}, int'(done_v), 0);
        @(negedge clk);
        #1;
        for (int g = 0; g < NDUT; g++)
            check($sformatf("%s_write_count[%0d]", tag, g), idx[g], NPIX);
    endtask

    task automatic fill(input int v);
        for (int p = 0; p < NPIX; p++) img[p] = PW'(v);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Flat image; start pulsed mid-scan must not disturb the scan.
        fill(50);
        check("model_flat", model_resp(3, 3), 0);
        run_scan("flat", 1'b1);
        check("flat_ram_thr0", nz(0), 0);

        // Single bright pixel at (3,3).
        fill(0);
        img[27] = 8'd200;
        check("model_peak", model_resp(3, 3), 80000);
        check("model_peak_nbr", model_resp(3, 4), 0);
        run_scan("peak", 1'b0);
        check("peak_ram27", ram[MAIN][27], 200);
        check("peak_ram28", ram[MAIN][28], 0);
        check("peak_ram_count", nz(MAIN), 1);

        // Vertical step edge: no corners at any threshold.
        for (int p = 0; p < NPIX; p++) img[p] = ((p % NS) >= 4) ? 8'd255 : 8'd0;
        check("model_edge", model_resp(3, 4), 0);
        run_scan("edge", 1'b0);
        for (int g = 0; g < NDUT; g++) check($sformatf("edge_ram_count[%0d]", g), nz(g), 0);

        // Threshold boundary: R = 200 at (2,5).
        fill(0);
        img[21] = 8'd10;
        check("model_thr", model_resp(2, 5), 200);
        run_scan("thr", 1'b0);
        check("thr200_ram21", ram[2][21], 0);
        check("thr199_ram21", ram[1][21], 10);
        check("thr199_ram_count", nz(1), 1);
        check("thr200_ram_count", nz(2), 0);

        // Reset 100 cycles into a scan, then a clean rescan.
        for (int p = 0; p < NPIX; p++) img[p] = PW'((p * 37 + 11) % 256);
        build_expected();
        pulse_start();
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_scan("rescan", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/moravec_detector.md
# moravec_detector

Scan engine directly upstream of the corner-map RAM (`v_rams_09` instance with `HarrisCont=0`). Walks an N×N source image held in the pixel RAM, one pixel at a time in raster order, using that RAM's asynchronous read port. For each pixel it computes a 3×3 Moravec response. It then issues one write per pixel to the corner-map RAM: `wr_data` is the pixel value and `harris_bit` is the corner decision, so the RAM stores the pixel at corners and 0 elsewhere.

## Interface
- `N`, 8: image side length in pixels.
- `bitSize`, 6: address MSB index; addresses are `bitSize+1` bits wide.
- `pixelWidth`, 8: pixel width P.
- `THRESH`, 17'd1000: corner threshold, width 2P+1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: scan request, sampled in IDLE only.
- `busy` output 1: scan in progress.
- `done` output 1: one-cycle pulse at scan end.
- `rd_addr` output bitSize+1: source RAM read address.
- `rd_data` input P: source RAM read data, combinational from `rd_addr` in the same cycle.
- `wr_en` output 1: drives the RAM `we`.
- `wr_addr` output bitSize+1: drives the RAM `primary_address`.
- `wr_data` output P: drives the RAM `data_in`.
- `harris_bit` output 1: drives the RAM `harrisBit`; 1 = corner.

## Operation
- Reset values: all outputs 0, state IDLE, pixel counter 0.
- States:
  - IDLE → START_PIX on `start`.
  - START_PIX (0 cycles, combinational decode of the pixel counter): to WRITE for a border pixel, otherwise to FETCH.
  - FETCH: 9 cycles, neighbour index k=0..8 in row-major order of the 3×3 window. `rd_addr` = (r-1+k/3)*N + (c-1+k%3). `rd_data` is latched into window register k at each edge.
  - CALC: 1 cycle; response registered.
  - WRITE: 2 cycles.
  - After WRITE: increment the pixel counter. If the counter was N*N-1, go to DONE; otherwise go to START_PIX.
  - DONE: 1 cycle, `done`=1, then IDLE.
- Border pixel: r==0, r==N-1, c==0 or c==N-1. No reads are issued; write `wr_data`=0, `harris_bit`=0.
- Response:
  - d_x = signed (P+1)-bit difference a−ctr. Squares are 2P bits. Each direction sum E is 2P+1 bits, unsigned.
  - E_H = (W−C)²+(E−C)².
  - E_V = (N−C)²+(S−C)².
  - E_D = (NW−C)²+(SE−C)².
  - E_A = (NE−C)²+(SW−C)².
  - R = min of the four. `harris_bit` = R > THRESH, strict.
- During WRITE:
  - `wr_en`=1 for both cycles.
  - `wr_addr` = r*N+c, `wr_data` = centre pixel, `harris_bit` = decision.
  - All three are held stable across both cycles. The downstream RAM commits only on alternate edges, so two cycles guarantee exactly one commit regardless of its phase.
- `wr_en`=0 and `rd_addr`=0 outside FETCH/WRITE.
- `start` while busy is ignored; there is no queueing.
- Reset mid-scan: immediate return to IDLE with outputs 0. Writes already committed downstream are not undone. A new `start` rescans from pixel 0.

## Timing
- Cost per pixel: interior 12 cycles (9+1+2); border 2 cycles.
- N=8: 36 interior + 28 border pixels = 488 cycles.
- `busy` rises on the edge that samples `start`.
- `done` rises 489 edges after the sampling edge and lasts 1 cycle. `busy` falls on the same edge that `done` rises.
- Read path: `rd_addr` is registered; `rd_data` is used in the same cycle (no read latency).
- Writes are emitted in ascending address order 0..N*N-1, exactly N*N writes per scan.

## Structure
- `moravec_pkg` holds:
  - state enum (IDLE, START_PIX, FETCH, CALC, WRITE, DONE);
  - neighbour index constants (NW=0 … SE=8, C=4);
  - response width function 2P+1.
- Sub-module `moravec_response`: purely combinational. Inputs: 9 pixels. Output: R. The FSM registers its result in CALC.

## Test plan
- Flat image (all 50), THRESH=0 → 64 writes, all `harris_bit`=0 (R=0 is not > 0); `done` at edge 489; corner RAM all 0.
- Single pixel 200 at (3,3), rest 0, THRESH=1000 → address 27 written with 200 and `harris_bit`=1 (R=80000). Neighbour (3,4) gets `harris_bit`=0 (E_V=0).
- Vertical edge: columns ≥4 = 255, rest 0 → no `harris_bit`=1 anywhere (E_V=0 along the edge); corner RAM all 0.
- Threshold boundary: single pixel 10 on a 0 background, so R=200. THRESH=200 → bit 0; THRESH=199 → bit 1 at that address only.
- Write protocol: `wr_en` high exactly 2 consecutive cycles per pixel with stable addr/data. Addresses 0..63 in order. `start` pulsed mid-scan has no effect.
- `rst_n` low at cycle 100 → all outputs 0 immediately without a clock edge. New `start` → full scan of 64 writes, `done` 489 edges later.
